lsu: RTL
========

# lsu

Load/store unit sitting between the core's decode/execute stage and the data cache. It accepts RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) through a valid/ready handshake and buffers them in a 2-entry queue. It runs one cache access at a time, waiting for the cache `valid`, with misalignment, illegal-funct3 and timeout faulting. It returns one single-cycle response per request.

## Interface
- `TIMEOUT`, default 64: number of ACCESS cycles without `dc_valid` before the access faults; legal range is 1..255.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  core presents a request.
- `req_ready`  out  1  queue can accept a request (queue count < 2).
- `req_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3 of the load/store.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `req_rd`  in  5  destination register for loads.
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_fault`  out  1  response is a fault (misaligned, illegal funct3 or timeout).
- `resp_rdata`  out  32  load result.
- `resp_rd`  out  5  destination register of the response.
- `dc_w_ena`  out  1  cache write enable.
- `dc_addr`  out  32  cache address.
- `dc_width`  out  3  access width: 001 = byte, 010 = half, 100 = word; 000 = no access.
- `dc_ext`  out  1  sign-extend the load result.
- `dc_data_in`  out  32  store data, right-aligned.
- `dc_valid`  in  1  cache has completed the access presented.
- `dc_data_out`  in  32  load data, already extended by the cache.

## Operation
- **Queue.** 2-entry FIFO holding {store, funct3, addr, wdata, rd}.
  - Push when `req_valid && req_ready`.
  - `req_ready` = count < 2. It is not combinationally relaxed by a same-cycle pop.
  - Push and pop on the same edge leave the count unchanged.
- **FSM states:** IDLE, ACCESS, RESP.
- **IDLE:** if the queue is non-empty, pop the head into the op register on this edge. Then:
  - If the op is illegal or misaligned, go to RESP with fault.
  - Otherwise go to ACCESS and clear the wait counter.
- **Illegal funct3:**
  - Loads: 011, 110, 111.
  - Stores: any funct3 with bit 2 set, or 011.
- **Misaligned:**
  - Half access with `addr[0]` = 1.
  - Word access with `addr[1:0]` ≠ 00.
- **ACCESS:** drive the cache from the op register:
  - `dc_width` is decoded from `funct3[1:0]`.
  - `dc_w_ena` = store.
  - `dc_ext` = load && !`funct3[2]`.
  - `dc_addr` = addr.
  - `dc_data_in` = wdata masked to the access width for stores, 0 for loads.
  - If `dc_valid` is high: capture `dc_data_out` (loads) or 0 (stores) and go to RESP with no fault.
  - Else, if the counter reaches `TIMEOUT` − 1: go to RESP with fault.
  - Else: increment the counter.
  - `dc_valid` takes priority over timeout on the same edge.
- **RESP:**
  - `resp_valid` = 1.
  - `resp_rd` = rd for loads, 0 for stores.
  - `resp_rdata` = captured data, or 0 on fault.
  - Next state is IDLE.
- **Outside ACCESS:**
  - All `dc_*` outputs are 0.
  - `dc_valid` is ignored.
- **Ordering:** responses are returned in request order; exactly one response per accepted request.

## Timing
- **Reset (asynchronous, active-low):**
  - Queue empty, FSM in IDLE, counter 0.
  - `resp_*` = 0, `dc_*` = 0, `req_ready` = 1.
  - Reset mid-ACCESS drops `dc_width` to 000 immediately. The in-flight op and all queued ops are discarded and no response is issued.
- **Legal access, empty IDLE unit, accepted at edge N:**
  - ACCESS occupies the cycles after edge N+1; the `dc_*` outputs are valid in the first of them.
  - If `dc_valid` is sampled high at edge N+1+k (k ≥ 1), `resp_valid` is high in the cycle after that edge.
  - Minimum latency, from accept edge to the response cycle, is 2 edges (edges N+1 and N+2).
- **Faulting request accepted at edge N:** `resp_valid` with `resp_fault` is high in the cycle after edge N+1; `dc_width` stays 000 throughout.
- **Timeout:** the fault response follows exactly `TIMEOUT` ACCESS cycles with `dc_valid` low.
- **Throughput:** IDLE → ACCESS → RESP → IDLE; at most one op per 3 cycles. Back-to-back queued ops start on the IDLE edge following RESP.
- **Stability:** `dc_*` outputs are stable for the whole of ACCESS.

## Test plan
- **LW:** reset, then LW addr 0x100, rd=5; `dc_valid` high in the first ACCESS cycle with `dc_data_out` = 0xDEADBEEF.
  - Required: `dc_width` = 100, `dc_w_ena` = 0.
  - Required: `resp_valid` 2 edges after accept, rdata = 0xDEADBEEF, rd = 5, fault = 0.
- **SB:** SB addr 0x203, wdata 0x12345678.
  - Required: `dc_width` = 001, `dc_w_ena` = 1, `dc_data_in` = 0x00000078, `dc_ext` = 0.
  - Required response: rd = 0, rdata = 0, fault = 0.
- **Misaligned / illegal:** LH addr 0x101, then LW funct3 = 011.
  - Required: two fault responses, `dc_width` = 000 throughout.
- **Timeout:** `TIMEOUT` = 4, LB with `dc_valid` held low.
  - Required: fault response after exactly 4 ACCESS cycles.
  - Variant: `dc_valid` first asserted in the 4th ACCESS cycle gives a success response.
- **Queue full / ordering:** push 3 requests back-to-back while the cache stalls 10 cycles.
  - Required: `req_ready` = 0 once 2 are queued.
  - Required: 3 responses in request order, no loss or duplication.
- **Reset mid-operation:** assert `rst` low during ACCESS with 1 op queued.
  - Required: `dc_width` = 000 immediately and no `resp_valid` afterwards.
  - Required: the next request after release completes normally.

Source files
------------

// File: rtl/lsu.sv
// RV32I load/store unit: 2-entry request queue feeding a single-outstanding
// data-cache access engine with alignment, funct3 and timeout faulting.
module lsu #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  output logic        resp_fault,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        dc_w_ena,
  output logic [31:0] dc_addr,
  output logic [2:0]  dc_width,
  output logic        dc_ext,
  output logic [31:0] dc_data_in,
  input  logic        dc_valid,
  input  logic [31:0] dc_data_out
);

  typedef struct packed {
    logic        store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
  } op_t;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  op_t         q_mem_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  count_q;
  logic        push, pop;
  op_t         head, push_op;

  state_e      state_q;
  op_t         op_q;
  logic [7:0]  cnt_q;
  logic        fault_q;
  logic [31:0] rdata_q;
  logic [31:0] mask;

  function automatic logic op_bad(input op_t o);
    logic illegal, misaligned;
    illegal    = o.store ? (o.funct3[2] || o.funct3[1:0] == 2'b11)
                         : (o.funct3 == 3'b011 || o.funct3 == 3'b110 || o.funct3 == 3'b111);
    misaligned = (o.funct3[1:0] == 2'b01 && o.addr[0]) ||
                 (o.funct3[1:0] == 2'b10 && o.addr[1:0] != 2'b00);
    return illegal || misaligned;
  endfunction

  assign req_ready = (count_q != 2'd2);
  assign push      = req_valid && req_ready;
  assign pop       = (state_q == IDLE) && (count_q != 2'd0);
  assign head      = q_mem_q[rd_ptr_q];
  assign push_op   = '{store: req_store, funct3: req_funct3, addr: req_addr,
                       wdata: req_wdata, rd: req_rd};

  always_ff @(posedge clk) begin
    if (push) q_mem_q[wr_ptr_q] <= push_op;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= !wr_ptr_q;
      if (pop)  rd_ptr_q <= !rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            op_q <= head;
            if (op_bad(head)) begin
              fault_q <= 1'b1;
              rdata_q <= '0;
              state_q <= RESP;
            end else begin
              cnt_q   <= '0;
              state_q <= ACCESS;
            end
          end
        end
        ACCESS: begin
          // completion wins over timeout when both land on the same edge
          if (dc_valid) begin
            fault_q <= 1'b0;
            rdata_q <= op_q.store ? '0 : dc_data_out;
            state_q <= RESP;
          end else if (cnt_q == 8'(TIMEOUT - 1)) begin
            fault_q <= 1'b1;
            rdata_q <= '0;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    dc_w_ena   = 1'b0;
    dc_addr    = '0;
    dc_width   = '0;
    dc_ext     = 1'b0;
    dc_data_in = '0;
    mask       = '0;
    if (state_q == ACCESS) begin
      case (op_q.funct3[1:0])
        2'b00:   begin dc_width = 3'b001; mask = 32'h0000_00FF; end
        2'b01:   begin dc_width = 3'b010; mask = 32'h0000_FFFF; end
        2'b10:   begin dc_width = 3'b100; mask = '1;            end
        default: begin dc_width = 3'b000; mask = '0;            end
      endcase
      dc_w_ena   = op_q.store;
      dc_addr    = op_q.addr;
      dc_ext     = !op_q.store && !op_q.funct3[2];
      dc_data_in = op_q.store ? (op_q.wdata & mask) : '0;
    end
  end

  always_comb begin
    resp_valid = (state_q == RESP);
    resp_fault = resp_valid && fault_q;
    resp_rdata = resp_valid ? rdata_q : '0;
    resp_rd    = (resp_valid && !op_q.store) ? op_q.rd : '0;
  end

endmodule
